// File: rtl/s2p_pkg.sv
// Shared definitions for the serial-to-parallel receiver.
//
// Contents: word width, frame length, receive FSM state encoding, bit
// counter width and an even-parity helper.
//
// Build option: define S2P_PARITY_EN to add a trailing even-parity beat to
// every frame (adds the PAR state and lengthens the frame to WORD_W + 1).
package s2p_pkg;

  localparam int WORD_W = 4;

`ifdef S2P_PARITY_EN
  localparam int FRAME_LEN = WORD_W + 1;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;
`else
  localparam int FRAME_LEN = WORD_W;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1
  } state_t;
`endif

  // Counter must reach FRAME_LEN - 1 (bits held while waiting in PAR).
  localparam int CNT_W = $clog2(FRAME_LEN + 1);
  // Bits needed to address one data bit of the shift register.
  localparam int IDX_W = $clog2(WORD_W);

  // Even parity: data bits plus parity bit must XOR to zero.
  function automatic logic even_parity_ok(input logic [WORD_W-1:0] data,
                                          input logic              par);
    return ~(^{data, par});
  endfunction

endpackage

// File: rtl/s2p_out_reg.sv
// Output holding register with valid/ready handshake and overflow flag.
//
// Ports:
//   clk, reset   - clock and synchronous active-high reset
//   word_load    - a completed word is offered this cycle
//   word_in      - the completed word
//   word_ready   - consumer accepts the held word this cycle
//   word_out     - held word, stable while word_valid is high
//   word_valid   - word_out holds an unconsumed word
//   overflow     - one-cycle pulse: an offered word was dropped (register full)
module s2p_out_reg
  import s2p_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              word_load,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  output logic              overflow
);

  // The register has room when it is empty or being drained this cycle, so
  // a word completing in the same cycle as a consume replaces it seamlessly.
  logic has_room;
  assign has_room = ~word_valid | word_ready;

  // NOTE: sequential state is assigned with <= so every flop samples the
  // pre-edge values of its peers, matching real hardware behaviour.
  always_ff @(posedge clk) begin
    if (reset) begin
      word_out   <= '0;
      word_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      overflow <= 1'b0;
      if (word_load) begin
        if (has_room) begin
          word_out   <= word_in;
          word_valid <= 1'b1;
        end else begin
          overflow <= 1'b1;
        end
      end else if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/serial_to_parallel.sv
// Serial-to-parallel receiver: assembles LSB-first serial beats into WORD_W
// bit words and hands them to a valid/ready output register.
//
// Ports:
//   clk, reset    - clock and synchronous active-high reset
//   serial_i      - serial data bit, qualified by valid_i
//   valid_i       - serial_i carries a frame bit this cycle
//   parallel_o    - assembled word, meaningful while word_valid_o = 1
//   word_valid_o  - parallel_o holds an unconsumed word
//   word_ready_i  - consumer accepts the word this cycle
//   busy_o        - a frame is partially received
//   overflow_o    - one-cycle pulse: completed word dropped, output full
//   parity_err_o  - one-cycle pulse: parity mismatch, word discarded
//
// Build option: S2P_PARITY_EN adds a 5th even-parity beat per frame;
// without it parity_err_o is tied to 0.
module serial_to_parallel
  import s2p_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              serial_i,
  input  logic              valid_i,
  output logic [WORD_W-1:0] parallel_o,
  output logic              word_valid_o,
  input  logic              word_ready_i,
  output logic              busy_o,
  output logic              overflow_o,
  output logic              parity_err_o
);

  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(WORD_W - 1);

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              complete;
`ifdef S2P_PARITY_EN
  logic              par_fail;
  logic              parity_err_q;
`endif

  // NOTE: every shift-register bit is reset explicitly; this is a handful
  // of flops, not a memory, so there is no cost to a defined start state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: all outputs of this block get a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    complete = 1'b0;
`ifdef S2P_PARITY_EN
    par_fail = 1'b0;
`endif
    if (valid_i) begin
      case (state_q)
        IDLE, RECV: begin
          // Each bit position is written exactly once per frame, so stale
          // bits from an earlier frame never survive into a new word.
          shift_d[cnt_q[IDX_W-1:0]] = serial_i;
          if (cnt_q == LAST_DATA) begin
`ifdef S2P_PARITY_EN
            state_d = PAR;
            cnt_d   = cnt_q + CNT_W'(1);
`else
            state_d  = IDLE;
            cnt_d    = '0;
            complete = 1'b1;
`endif
          end else begin
            state_d = RECV;
            cnt_d   = cnt_q + CNT_W'(1);
          end
        end
`ifdef S2P_PARITY_EN
        PAR: begin
          state_d = IDLE;
          cnt_d   = '0;
          if (even_parity_ok(shift_q, serial_i)) begin
            complete = 1'b1;
          end else begin
            par_fail = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign busy_o = (state_q != IDLE);

  // shift_d already contains the completing bit (or equals shift_q on the
  // parity beat), so it is the finished word whenever complete is high.
  s2p_out_reg u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .word_load (complete),
    .word_in   (shift_d),
    .word_ready(word_ready_i),
    .word_out  (parallel_o),
    .word_valid(word_valid_o),
    .overflow  (overflow_o)
  );

`ifdef S2P_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= par_fail;
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel. Stimulus pushes expected words into
// a queue; a monitor pops and compares each word as it is consumed.
module tb_serial_to_parallel;
  import s2p_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              serial_i;
  logic              valid_i;
  logic [WORD_W-1:0] parallel_o;
  logic              word_valid_o;
  logic              word_ready_i;
  logic              busy_o;
  logic              overflow_o;
  logic              parity_err_o;

  int tests_run = 0;
  int tests_failed = 0;
  logic [WORD_W-1:0] exp_q[$];

  serial_to_parallel dut (
    .clk         (clk),
    .reset       (reset),
    .serial_i    (serial_i),
    .valid_i     (valid_i),
    .parallel_o  (parallel_o),
    .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i),
    .busy_o      (busy_o),
    .overflow_o  (overflow_o),
    .parity_err_o(parity_err_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: a word is consumed when valid and ready are both high at the
  // coming edge; sampled on the falling edge where inputs are stable.
  always @(negedge clk) begin
    if (!reset && word_valid_o && word_ready_i) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $display("FAIL unexpected_word: got 0x%0h, expected no word", parallel_o);
      end else begin
        check("consumed_word", 32'(parallel_o), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    serial_i = b;
    valid_i  = 1'b1;
    tick();
    valid_i  = 1'b0;
    serial_i = 1'b0;
  endtask

  // Sends a full frame; optionally raises ready together with the final beat
  // and optionally corrupts the parity beat.
  task automatic send_frame(input logic [3:0] w, input bit ready_on_last,
                            input bit bad_parity);
    for (int i = 0; i < 4; i++) begin
`ifndef S2P_PARITY_EN
      if (i == 3 && ready_on_last) word_ready_i = 1'b1;
`endif
      beat(w[i]);
    end
`ifdef S2P_PARITY_EN
    if (ready_on_last) word_ready_i = 1'b1;
    beat((^w) ^ bad_parity);
`else
    if (bad_parity) $display("note: parity corruption ignored in this build");
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    serial_i     = 1'b0;
    valid_i      = 1'b0;
    word_ready_i = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("reset_parallel", 32'(parallel_o), 32'h0);
    check("reset_valid", 32'(word_valid_o), 32'h0);
    check("reset_busy", 32'(busy_o), 32'h0);
    check("reset_overflow", 32'(overflow_o), 32'h0);
    check("reset_parity_err", 32'(parity_err_o), 32'h0);
    tick();
    reset = 1'b0;
    word_ready_i = 1'b1;

    // Beats 1,0,1,1 -> 4'hD visible one cycle after the last beat.
    exp_q.push_back(4'hD);
    send_frame(4'hD, 1'b0, 1'b0);
    @(negedge clk);
    check("d_valid_latency", 32'(word_valid_o), 32'h1);
    check("d_parallel", 32'(parallel_o), 32'hD);
    check("d_busy_after", 32'(busy_o), 32'h0);
    tick();
    tick();

    // Beats 0,1 / three idle cycles / beats 1,0 -> 4'h6, busy held.
    exp_q.push_back(4'h6);
    beat(1'b0);
    beat(1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("gap_busy", 32'(busy_o), 32'h1);
      tick();
    end
    beat(1'b1);
    beat(1'b0);
`ifdef S2P_PARITY_EN
    beat(1'b0);
`endif
    @(negedge clk);
    check("gap_valid", 32'(word_valid_o), 32'h1);
    tick();
    tick();

    // Ready low: 4'hA held, 4'h3 dropped with one overflow pulse.
    word_ready_i = 1'b0;
    exp_q.push_back(4'hA);
    send_frame(4'hA, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_none_first", 32'(overflow_o), 32'h0);
    send_frame(4'h3, 1'b0, 1'b0);
    @(negedge clk);
    check("ovf_pulse", 32'(overflow_o), 32'h1);
    check("ovf_held_word", 32'(parallel_o), 32'hA);
    tick();
    @(negedge clk);
    check("ovf_pulse_end", 32'(overflow_o), 32'h0);
    check("ovf_still_valid", 32'(word_valid_o), 32'h1);
    tick();
    word_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("ovf_drained", 32'(word_valid_o), 32'h0);
    tick();

    // 4'h5 completes in the same cycle 4'hA is consumed.
    word_ready_i = 1'b0;
    exp_q.push_back(4'hA);
    send_frame(4'hA, 1'b0, 1'b0);
    exp_q.push_back(4'h5);
    send_frame(4'h5, 1'b1, 1'b0);
    @(negedge clk);
    check("swap_valid", 32'(word_valid_o), 32'h1);
    check("swap_parallel", 32'(parallel_o), 32'h5);
    check("swap_overflow", 32'(overflow_o), 32'h0);
    tick();
    tick();

    // Reset after two beats, then a clean 4'h9.
    beat(1'b1);
    beat(1'b1);
    @(negedge clk);
    check("abort_busy_before", 32'(busy_o), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("abort_busy_after", 32'(busy_o), 32'h0);
    exp_q.push_back(4'h9);
    send_frame(4'h9, 1'b0, 1'b0);
    @(negedge clk);
    check("abort_parallel", 32'(parallel_o), 32'h9);
    tick();
    tick();

    // Reset discards a held word.
    word_ready_i = 1'b0;
    send_frame(4'hF, 1'b0, 1'b0);
    @(negedge clk);
    check("held_before_reset", 32'(word_valid_o), 32'h1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    @(negedge clk);
    check("held_after_reset", 32'(word_valid_o), 32'h0);
    check("held_parallel_cleared", 32'(parallel_o), 32'h0);
    word_ready_i = 1'b1;
    tick();

`ifdef S2P_PARITY_EN
    // 4'h7 has odd weight, so parity bit 1 is correct and 0 is an error.
    exp_q.push_back(4'h7);
    send_frame(4'h7, 1'b0, 1'b0);
    @(negedge clk);
    check("par_ok_valid", 32'(word_valid_o), 32'h1);
    check("par_ok_err", 32'(parity_err_o), 32'h0);
    tick();
    tick();
    send_frame(4'h7, 1'b0, 1'b1);
    @(negedge clk);
    check("par_bad_err", 32'(parity_err_o), 32'h1);
    check("par_bad_valid", 32'(word_valid_o), 32'h0);
    tick();
    @(negedge clk);
    check("par_bad_err_end", 32'(parity_err_o), 32'h0);
`else
    @(negedge clk);
    check("parity_tied_low", 32'(parity_err_o), 32'h0);
`endif

    tick();
    tick();
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
